// File: rtl/decoder_nto2n_seq.sv
// Registered N-to-2^N one-hot decoder with held, single-strobe and auto-scan modes.
// Outputs are registered copies of the next-state decode, giving one cycle of latency from load.
module decoder_nto2n_seq #(
   parameter int N     = 2,
   parameter int DWELL = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            load,
   input  logic [1:0]      mode,
   input  logic [N-1:0]    sel,
   output logic [2**N-1:0] d,
   output logic [N-1:0]    idx,
   output logic            busy
);

   localparam int W  = 2**N;
   localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

   typedef enum logic [1:0] {IDLE, HOLD, STROBE, SCAN} state_t;

   state_t          state_q, state_d;
   logic [N-1:0]    idx_q, idx_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [W-1:0]    dec_q, dec_d;
   logic            busy_q, busy_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         dec_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         dec_q   <= dec_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      // en low dominates load; the latched mode lives in the state itself
      if (!en) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else if (load) begin
         cnt_d = '0;
         unique case (mode)
            2'b00:   state_d = HOLD;
            2'b01:   state_d = STROBE;
            2'b10:   state_d = SCAN;
            default: state_d = IDLE;
         endcase
         if (mode != 2'b11) idx_d = sel;
      end else begin
         unique case (state_q)
            STROBE: state_d = IDLE;
            SCAN: begin
               if (cnt_q == CW'(DWELL-1)) begin
                  cnt_d = '0;
                  idx_d = idx_q + 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
      busy_d = (state_d != IDLE);
      dec_d  = busy_d ? (W'(1) << idx_d) : '0;
   end

   assign d    = dec_q;
   assign idx  = idx_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_decoder_nto2n_seq.sv
// Scoreboard bench: two decoder configurations driven from one stimulus task,
// checked against a cycles-since-load reference model.
module tb_decoder_nto2n_seq;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic       en_a = 1'b0, ld_a = 1'b0;
   logic [1:0] md_a = '0;
   logic [1:0] sel_a = '0;
   logic [3:0] d_a;
   logic [1:0] idx_a;
   logic       busy_a;

   logic       en_b = 1'b0, ld_b = 1'b0;
   logic [1:0] md_b = '0;
   logic [2:0] sel_b = '0;
   logic [7:0] d_b;
   logic [2:0] idx_b;
   logic       busy_b;

   decoder_nto2n_seq #(.N(2), .DWELL(3)) u_a (
      .clk(clk), .rst(rst), .en(en_a), .load(ld_a), .mode(md_a), .sel(sel_a),
      .d(d_a), .idx(idx_a), .busy(busy_a));

   decoder_nto2n_seq #(.N(3), .DWELL(1)) u_b (
      .clk(clk), .rst(rst), .en(en_b), .load(ld_b), .mode(md_b), .sel(sel_b),
      .d(d_b), .idx(idx_b), .busy(busy_b));

   // st: 0 idle, 1 hold, 2 strobe, 3 scan; t counts cycles since the load
   typedef struct {int st; int sel; int t; int idx;} mdl_t;
   typedef struct {logic [7:0] d; logic [2:0] idx; logic busy;} exp_t;

   mdl_t ma = '{0, 0, 0, 0};
   mdl_t mb = '{0, 0, 0, 0};
   exp_t qa[$];
   exp_t qb[$];
   int   cmp = 0;
   int   errs = 0;
   int   cur = 0;

   function automatic mdl_t step(mdl_t m, int n, int dw, bit r, bit e, bit ld, int md, int s);
      mdl_t x = m;
      if (r) begin
         x.st = 0; x.idx = 0; x.t = 0;
      end else if (!e) begin
         x.st = 0;
      end else if (ld) begin
         if (md == 3) x.st = 0;
         else begin
            x.st = md + 1; x.sel = s; x.t = 0; x.idx = s;
         end
      end else if (x.st == 2) begin
         x.st = 0;
      end else if (x.st == 3) begin
         x.t++;
         x.idx = (x.sel + x.t / dw) % (1 << n);
      end
      return x;
   endfunction

   function automatic exp_t expect_of(mdl_t m);
      exp_t e;
      e.busy = (m.st != 0);
      e.idx  = 3'(m.idx);
      e.d    = e.busy ? (8'd1 << m.idx) : 8'd0;
      return e;
   endfunction

   task automatic chk(string nm, logic [7:0] d, logic [2:0] ix, logic b, exp_t e);
      cmp++;
      if (d !== e.d || ix !== e.idx || b !== e.busy || (d & (d - 8'd1)) != 8'd0) begin
         errs++;
         $display("FAIL %s @%0t: got d=%b idx=%0d busy=%b, want d=%b idx=%0d busy=%b",
                  nm, $time, d, ix, b, e.d, e.idx, e.busy);
      end
   endtask

   // one stimulus cycle for the selected DUT; the other one sees en=0
   task automatic cyc(bit r, bit ld, int md, int s, bit e);
      bit rose;
      @(negedge clk);
      rose = r && !rst;
      rst  = r;
      en_a = (cur == 0) ? e : 1'b0;  ld_a = (cur == 0) ? ld : 1'b0;
      md_a = 2'(md);                 sel_a = 2'(s % 4);
      en_b = (cur == 1) ? e : 1'b0;  ld_b = (cur == 1) ? ld : 1'b0;
      md_b = 2'(md);                 sel_b = 3'(s % 8);
      ma = step(ma, 2, 3, r, en_a, ld_a, md, s % 4);
      mb = step(mb, 3, 1, r, en_b, ld_b, md, s % 8);
      qa.push_back(expect_of(ma));
      qb.push_back(expect_of(mb));
      if (rose) begin
         exp_t z = '{8'd0, 3'd0, 1'b0};
         #1;
         chk("async_rst_a", {4'd0, d_a}, {1'b0, idx_a}, busy_a, z);
         chk("async_rst_b", d_b, idx_b, busy_b, z);
      end
   endtask

   task automatic idle(int n, bit e = 1'b1);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, e);
   endtask

   always @(posedge clk) begin
      exp_t ea, eb;
      #1;
      if (qa.size() > 0) begin
         ea = qa.pop_front();
         chk("dut_a", {4'd0, d_a}, {1'b0, idx_a}, busy_a, ea);
      end
      if (qb.size() > 0) begin
         eb = qb.pop_front();
         chk("dut_b", d_b, idx_b, busy_b, eb);
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("reset_a", {4'd0, d_a}, {1'b0, idx_a}, busy_a, '{8'd0, 3'd0, 1'b0});
      cur = 0;
      idle(10);
      cyc(0, 1, 0, 2, 1);  idle(20);          // hold on 2
      cyc(0, 1, 0, 1, 1);  idle(3);           // re-decode to 1
      cyc(0, 1, 3, 2, 1);  idle(3);           // reserved -> idle
      cyc(0, 1, 1, 3, 1);  idle(3);           // single strobe
      cyc(0, 1, 1, 0, 1);  cyc(0, 1, 1, 1, 1);  idle(3);
      cyc(0, 1, 2, 2, 1);  idle(14);          // scan with wrap
      cyc(0, 1, 2, 0, 1);  idle(4);           // restart mid-dwell
      cyc(0, 0, 0, 0, 0);  idle(3);           // en low
      cyc(0, 1, 2, 1, 1);  idle(2);
      cyc(0, 1, 0, 3, 0);  idle(2);           // load with en low
      cyc(0, 1, 2, 3, 1);  idle(4);
      cyc(1, 0, 0, 0, 1);  cyc(1, 0, 0, 0, 1);  idle(3);
      cur = 1;
      cyc(0, 1, 2, 0, 1);  idle(18);          // DWELL=1 walk through 8 bits
      cyc(0, 1, 2, 6, 1);  idle(4);
      for (int k = 0; k < 2; k++) begin
         cur = k;
         for (int i = 0; i < 400; i++)
            cyc(($urandom % 97) == 0, ($urandom % 4) == 0, int'($urandom % 4),
                int'($urandom % 8), ($urandom % 12) != 0);
      end
      idle(1);
      repeat (2) @(posedge clk);
      #2;
      if (qa.size() != 0 || qb.size() != 0) begin
         errs++;
         $display("FAIL drain: got %0d/%0d pending, want 0/0", qa.size(), qb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
      $finish;
   end

endmodule
